fetch_ctrl: RTL

Instruction-fetch sequencer that drives the address side of the synchronous instruction ROM and turns its 1-cycle-latency read data into a valid/ready instruction stream for decode. It owns the fetch PC, sequential increment, redirect (branch/jump) handling, and back-pressure. Back-pressure is handled by re-presenting the stalled address, since ROM reads are side-effect free. It sits between the ROM and the decode stage and flags out-of-range or misaligned fetch addresses.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch types, constants and the address legality helper.
// pc_legal is also intended for data-memory range checks.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSN_BYTES = 4;

    // Compared in 64 bits so a large word count cannot overflow the limit.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned words);
        logic [63:0] limit;
        limit = 64'(words) * 64'(INSN_BYTES);
        return (pc[1:0] == 2'b00) && ({32'd0, pc} < limit);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the ROM address and presents its 1-cycle data as a valid/ready stream.
// Redirect reaches o_valid in 1 cycle; stalls re-present the held address so the ROM re-reads the same word.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned ROM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_rom_pc,
    input  logic [31:0] i_rom_insn,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_insn,
    output logic        o_fault
);

    localparam logic [31:0] STEP = 32'(INSN_BYTES);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_pc, fetch_pc_n;
    logic [31:0]  rsp_pc, rsp_pc_n;
    logic         rsp_valid, rsp_valid_n;

    logic valid_now;
    logic stall;
    logic redirect_legal;
    logic fetch_legal;

    assign valid_now      = !rst && rsp_valid && (state == RUN) && !i_redirect;
    assign stall          = valid_now && !i_ready;
    assign redirect_legal = pc_legal(i_redirect_pc, ROM_WORDS);
    assign fetch_legal    = pc_legal(fetch_pc, ROM_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            rsp_pc    <= rsp_pc_n;
            rsp_valid <= rsp_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        rsp_pc_n    = rsp_pc;
        rsp_valid_n = rsp_valid;
        case (state)
            BOOT: begin
                state_n     = RUN;
                rsp_pc_n    = fetch_pc;
                rsp_valid_n = 1'b1;
                fetch_pc_n  = fetch_pc + STEP;
            end
            RUN: begin
                if (i_redirect && redirect_legal) begin
                    rsp_pc_n    = i_redirect_pc;
                    rsp_valid_n = 1'b1;
                    fetch_pc_n  = i_redirect_pc + STEP;
                end else if (i_redirect) begin
                    state_n     = FAULT;
                    rsp_valid_n = 1'b0;
                end else if (stall) begin
                    state_n = RUN;
                end else if (fetch_legal) begin
                    rsp_pc_n    = fetch_pc;
                    rsp_valid_n = 1'b1;
                    fetch_pc_n  = fetch_pc + STEP;
                end else begin
                    // Walked off the ROM end; the last legal word was already delivered.
                    state_n     = FAULT;
                    rsp_valid_n = 1'b0;
                end
            end
            FAULT: begin
                if (i_redirect && redirect_legal) begin
                    state_n     = RUN;
                    rsp_pc_n    = i_redirect_pc;
                    rsp_valid_n = 1'b1;
                    fetch_pc_n  = i_redirect_pc + STEP;
                end
            end
            default: begin
                state_n     = BOOT;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_valid = valid_now;
        o_fault = !rst && (state == FAULT);
        o_pc    = rsp_pc;
        o_insn  = i_rom_insn;
        if (rst) begin
            o_rom_pc = RESET_PC;
        end else if (i_redirect) begin
            o_rom_pc = i_redirect_pc;
        end else if (stall) begin
            o_rom_pc = rsp_pc;
        end else begin
            o_rom_pc = fetch_pc;
        end
    end

endmodule
